// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-multiplexed FIR MAC stage:
//   FIR_TAPS     number of taps / coefficients (8)
//   fir_state_t  FSM state encoding (IDLE -> MAC -> DONE -> IDLE)
//   coef_rst()   reset value of coefficient k, default set {1,2,3,4,4,3,2,1}
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_TAPS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } fir_state_t;

  // Default coefficient set, symmetric low-pass shape; coef0 pairs with the
  // newest tap A0.
  function automatic logic signed [7:0] coef_rst(input logic [2:0] k);
    case (k)
      3'd0:    coef_rst = 8'sd1;
      3'd1:    coef_rst = 8'sd2;
      3'd2:    coef_rst = 8'sd3;
      3'd3:    coef_rst = 8'sd4;
      3'd4:    coef_rst = 8'sd4;
      3'd5:    coef_rst = 8'sd3;
      3'd6:    coef_rst = 8'sd2;
      3'd7:    coef_rst = 8'sd1;
      default: coef_rst = 8'sd0;
    endcase
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// -----------------------------------------------------------------------------
// fir_coef_bank
// 8 x COEF_W coefficient register file with one write port and one
// asynchronous read port.
// Ports:
//   clk, reset   clock and asynchronous active-high reset (reloads defaults)
//   idle         write enable qualifier; writes land only while the MAC is idle
//   we           write strobe
//   waddr/wdata  write index and data
//   raddr/rdata  combinational read port (indexed by the MAC step counter)
// -----------------------------------------------------------------------------
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idle,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [COEF_W-1:0] wdata,
  input  logic [2:0]        raddr,
  output logic [COEF_W-1:0] rdata
);

  logic [COEF_W-1:0] mem [FIR_TAPS];

  // Coefficient storage: reset reloads the default set, writes only in idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < FIR_TAPS; k++) begin
        mem[k] <= COEF_W'(coef_rst(3'(k)));
      end
    end else if (we && idle) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_mac_seq.sv
// -----------------------------------------------------------------------------
// fir_mac_seq
// Time-multiplexed 8-tap FIR multiply-accumulate stage. On in_valid (while
// idle) the taps A0..A7 are latched and 8 serial MACs run against the
// programmable coefficient bank; one scaled result is emitted with a single
// cycle out_valid pulse. A pass takes 10 cycles including the accept cycle.
//
// Build option: define FIR_SAT_EN to clamp the scaled result to the OUT_W
// signed range and pulse sat_hit when clamping occurs; without it the result
// wraps to the low OUT_W bits and sat_hit stays 0.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   in_valid       start request; taps sampled on the accepting edge only
//   A0..A7         taps, A0 newest, A7 oldest (unsigned)
//   coef_we        coefficient write strobe (honoured only while idle)
//   coef_addr      coefficient index; coef[k] multiplies Ak
//   coef_wdata     coefficient value (signed)
//   busy           high while a pass is in flight (state != IDLE)
//   out_valid      one-cycle result strobe
//   y              filter output, held until the next out_valid
//   overrun        sticky: request or write arrived while busy
//   sat_hit        pulses with out_valid when the result was clamped
// -----------------------------------------------------------------------------
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 19,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] A1,
  input  logic [DATA_W-1:0] A2,
  input  logic [DATA_W-1:0] A3,
  input  logic [DATA_W-1:0] A4,
  input  logic [DATA_W-1:0] A5,
  input  logic [DATA_W-1:0] A6,
  input  logic [DATA_W-1:0] A7,
  input  logic              coef_we,
  input  logic [2:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              busy,
  output logic              out_valid,
  output logic [OUT_W-1:0]  y,
  output logic              overrun,
  output logic              sat_hit
);

  localparam int PROD_W = DATA_W + COEF_W + 1;

  fir_state_t              state;
  fir_state_t              state_next;
  logic [2:0]              idx;
  logic signed [ACC_W-1:0] acc;
  logic [DATA_W-1:0]       taps [FIR_TAPS];
  logic [DATA_W-1:0]       tap_sel;
  logic [COEF_W-1:0]       coef_rd;
  logic signed [PROD_W-1:0] tap_ext;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] prod;
  logic                    idle;
  logic                    accept;
  logic                    mac_step;
  logic                    finish;
  logic [OUT_W-1:0]        scaled_y;
  logic                    sat_flag;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one accept edge, eight MAC edges, one output edge.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = ST_MAC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (idx == 3'd7) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_MAC;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath.
  always_comb begin
    idle     = 1'b0;
    accept   = 1'b0;
    mac_step = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        idle   = 1'b1;
        accept = in_valid;
      end
      ST_MAC:  mac_step = 1'b1;
      ST_DONE: finish   = 1'b1;
      default: idle     = 1'b0;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Coefficient bank; read port follows the MAC step counter.
  // ---------------------------------------------------------------------------
  fir_coef_bank #(
    .COEF_W (COEF_W)
  ) u_coef_bank (
    .clk    (clk),
    .reset  (reset),
    .idle   (idle),
    .we     (coef_we),
    .waddr  (coef_addr),
    .wdata  (coef_wdata),
    .raddr  (idx),
    .rdata  (coef_rd)
  );

  // ---------------------------------------------------------------------------
  // MAC datapath
  // ---------------------------------------------------------------------------
  assign tap_sel  = taps[idx];
  // Taps are unsigned: zero-extend. Coefficients are signed: sign-extend.
  assign tap_ext  = PROD_W'({1'b0, tap_sel});
  assign coef_ext = PROD_W'($signed(coef_rd));
  assign prod     = tap_ext * coef_ext;

  // Tap capture, accumulate, and result registration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < FIR_TAPS; k++) begin
        taps[k] <= '0;
      end
      idx       <= 3'd0;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      sat_hit   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      sat_hit   <= 1'b0;
      if (accept) begin
        taps[0] <= A0;
        taps[1] <= A1;
        taps[2] <= A2;
        taps[3] <= A3;
        taps[4] <= A4;
        taps[5] <= A5;
        taps[6] <= A6;
        taps[7] <= A7;
        idx     <= 3'd0;
        acc     <= '0;
      end else if (mac_step) begin
        acc <= acc + ACC_W'(prod);
        idx <= idx + 3'd1;
      end else if (finish) begin
        y         <= scaled_y;
        out_valid <= 1'b1;
        sat_hit   <= sat_flag;
      end
    end
  end

  // Sticky overrun: any request or coefficient write outside IDLE is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (!idle && (in_valid || coef_we)) begin
      overrun <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output scaler
  // ---------------------------------------------------------------------------
`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  // Shift then clamp into the signed OUT_W range.
  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted > OUT_MAX) begin
      scaled_y = OUT_MAX[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (shifted < OUT_MIN) begin
      scaled_y = OUT_MIN[OUT_W-1:0];
      sat_flag = 1'b1;
    end else begin
      scaled_y = shifted[OUT_W-1:0];
      sat_flag = 1'b0;
    end
  end
`else
  // Shift then keep the low OUT_W bits (two's-complement wrap).
  always_comb begin
    scaled_y = OUT_W'(acc >>> SHIFT);
    sat_flag = 1'b0;
  end
`endif

endmodule

// File: tb/tb_fir_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_seq
// Directed bench for fir_mac_seq: reset state, default-coefficient read-back,
// hand-computed filter results, saturation/wrap, overrun handling, mid-pass
// reset, and a paced 128-sample run against a bench-side reference model.
// -----------------------------------------------------------------------------
module tb_fir_mac_seq;

`ifdef FIR_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  A0, A1, A2, A3, A4, A5, A6, A7;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [7:0]  coef_wdata;
  logic        busy;
  logic        out_valid;
  logic [15:0] y;
  logic        overrun;
  logic        sat_hit;

  int nvec = 0;
  int nerr = 0;
  int coef_m [8];
  int rst_c  [8] = '{1, 2, 3, 4, 4, 3, 2, 1};

  always #5 clk = ~clk;

  fir_mac_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .A0         (A0),
    .A1         (A1),
    .A2         (A2),
    .A3         (A3),
    .A4         (A4),
    .A5         (A5),
    .A6         (A6),
    .A7         (A7),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .busy       (busy),
    .out_valid  (out_valid),
    .y          (y),
    .overrun    (overrun),
    .sat_hit    (sat_hit)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_taps(input logic [63:0] t);
    A0 = t[7:0];   A1 = t[15:8];  A2 = t[23:16]; A3 = t[31:24];
    A4 = t[39:32]; A5 = t[47:40]; A6 = t[55:48]; A7 = t[63:56];
  endtask

  function automatic int raw_acc(input logic [63:0] t);
    int acc = 0;
    for (int k = 0; k < 8; k++) acc += int'(t[8*k +: 8]) * coef_m[k];
    return acc;
  endfunction

  function automatic int scale_y(input int acc);
    if (SAT_ON) begin
      if (acc > 32767) return 32767;
      else if (acc < -32768) return -32768;
      else return acc;
    end else begin
      return int'($signed(acc[15:0]));
    end
  endfunction

  function automatic int scale_sat(input int acc);
    return (SAT_ON && (acc > 32767 || acc < -32768)) ? 1 : 0;
  endfunction

  task automatic write_coef(input logic [2:0] a, input logic [7:0] d);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    tick();
    coef_we = 1'b0;
    coef_m[a] = int'($signed(d));
  endtask

  // One full pass: optional same-edge coefficient write, taps scrambled
  // after acceptance, latency/busy/result/pulse-width checks.
  task automatic run_pass(input logic [63:0] t, input logic we, input logic [2:0] wa,
                          input logic [7:0] wd, input int exp_y, input int exp_sat,
                          input string tag);
    int lat;
    int bcnt;
    int got;
    set_taps(t);
    in_valid = 1'b1; coef_we = we; coef_addr = wa; coef_wdata = wd;
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    if (we) coef_m[wa] = int'($signed(wd));
    set_taps(~t);
    lat = 0; bcnt = 0; got = 0;
    while (got == 0 && lat < 20) begin
      if (busy) bcnt++;
      tick();
      lat++;
      got = out_valid ? 1 : 0;
    end
    check({tag, "_ovalid"}, got, 1);
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busycyc"}, bcnt, 9);
    check({tag, "_y"}, $signed(y), exp_y);
    check({tag, "_sat"}, sat_hit, exp_sat);
    check({tag, "_idle"}, busy, 0);
    tick();
    check({tag, "_pulse"}, out_valid, 0);
  endtask

  initial begin
    logic [63:0] t;
    int          lat;
    int          extra;
    int          exp_y;

    reset = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
    coef_addr = 3'd0; coef_wdata = 8'd0;
    set_taps(64'd0);
    for (int k = 0; k < 8; k++) coef_m[k] = rst_c[k];

    // 1: reset held 3 cycles
    tick(); tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_y", $signed(y), 0);
    check("rst_overrun", overrun, 0);
    check("rst_sat", sat_hit, 0);
    reset = 1'b0;
    tick();
    check("post_rst_busy", busy, 0);

    // default coefficient read-back through one-hot taps
    for (int k = 0; k < 8; k++) begin
      t = 64'd1 << (8 * k);
      run_pass(t, 1'b0, 3'd0, 8'd0, rst_c[k], 0, "coefrst");
    end

    // 2: default coefs, all taps 10 -> 20*10
    run_pass(64'h0A0A_0A0A_0A0A_0A0A, 1'b0, 3'd0, 8'd0, 200, 0, "t2");
    check("t2_overrun", overrun, 0);

    // 3: coef[1..7]=0, coef[0]=-128 written on the accepting edge, A0=255
    for (int k = 1; k < 8; k++) write_coef(3'(k), 8'd0);
    run_pass(64'h0000_0000_0000_00FF, 1'b1, 3'd0, 8'h80, -32640, 0, "t3");

    // 4: all coefs 127, all taps 255 -> acc 259080
    for (int k = 0; k < 8; k++) write_coef(3'(k), 8'd127);
`ifdef FIR_SAT_EN
    run_pass(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 8'd0, 32767, 1, "t4");
`else
    run_pass(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 8'd0, -3064, 0, "t4");
`endif

    // paced run: random coefficients, one sample every 16 cycles
    for (int k = 0; k < 8; k++) write_coef(3'(k), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 128; i++) begin
      t = {$urandom, $urandom};
      run_pass(t, 1'b0, 3'd0, 8'd0, scale_y(raw_acc(t)), scale_sat(raw_acc(t)), "pace");
      repeat (5) tick();
    end
    check("pace_overrun", overrun, 0);

    // 5: in_valid at E2, coef_we to addr 3 at E3; both dropped
    t = {$urandom, $urandom};
    exp_y = scale_y(raw_acc(t));
    set_taps(t);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; coef_we = 1'b1; coef_addr = 3'd3; coef_wdata = 8'(~coef_m[3]);
    tick();
    coef_we = 1'b0;
    lat = 3;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("t5_ovalid", out_valid, 1);
    check("t5_latency", lat, 9);
    check("t5_y", $signed(y), exp_y);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) extra++;
    end
    check("t5_no_second", extra, 0);
    check("t5_overrun", overrun, 1);
    run_pass(64'h0000_0000_0100_0000, 1'b0, 3'd0, 8'd0, coef_m[3], 0, "t5_coef3");
    check("t5_overrun_sticky", overrun, 1);

    // 6: reset asserted mid-pass (after E3, before E4)
    set_taps(64'h0A0A_0A0A_0A0A_0A0A);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_ovalid", out_valid, 0);
    check("t6_y", $signed(y), 0);
    check("t6_overrun", overrun, 0);
    tick(); tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) coef_m[k] = rst_c[k];
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) extra++;
    end
    check("t6_no_ovalid", extra, 0);
    run_pass(64'h0A0A_0A0A_0A0A_0A0A, 1'b0, 3'd0, 8'd0, 200, 0, "t6_fresh");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
